nbody_pair_sched: RTL and testbench

NBODY_PAIR_SCHED -- requirements
Module: nbody_pair_sched

---
 rtl/nbody_pair_sched.sv | 183 ++++++++++++++++++
 tb/tb_nbody_pair_sched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/nbody_pair_sched.sv
// N-body pair scheduler: issues (i,j) pairs into the acceleration pipeline, then sweeps the position update.
// Optional macro NBODY_SKIP_SELF_EN suppresses i==j pairs.
module nbody_pair_sched #(
  parameter int BODIES          = 512,
  parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
  parameter int ACCL_LATENCY    = 121,
  parameter int UPD_LATENCY     = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       ack,
  input  logic                       abort,
  input  logic [BODY_ADDR_WIDTH:0]   num_bodies,
  input  logic [15:0]                num_steps,
  output logic [BODY_ADDR_WIDTH-1:0] rd_i,
  output logic [BODY_ADDR_WIDTH-1:0] rd_j,
  output logic                       issue_valid,
  output logic                       res_valid,
  output logic [BODY_ADDR_WIDTH-1:0] res_i,
  output logic                       res_last,
  output logic [BODY_ADDR_WIDTH-1:0] pos_rd_addr,
  output logic [BODY_ADDR_WIDTH-1:0] pos_wr_addr,
  output logic                       pos_wren,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                step_count
);
  localparam int AW = BODY_ADDR_WIDTH;

`ifdef NBODY_SKIP_SELF_EN
  localparam bit SKIP_SELF = 1'b1;
`else
  localparam bit SKIP_SELF = 1'b0;
`endif

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [AW:0]   BODIES_W   = (AW+1)'(BODIES);
  localparam logic [AW:0]   ONE_N      = (AW+1)'(1);
  localparam logic [AW:0]   TWO_N      = (AW+1)'(2);
  localparam logic [AW:0]   MIN_PAIR_N = SKIP_SELF ? TWO_N : ONE_N;
  localparam logic [AW-1:0] ONE_A      = AW'(1);
  localparam logic [AW-1:0] FIRST_J    = SKIP_SELF ? ONE_A : '0;

  logic [2:0]    state;
  logic          start_q;
  logic [AW:0]   n_lat;
  logic [15:0]   s_lat;
  logic [AW-1:0] i_cnt, j_cnt, u_cnt;
  logic          rd_done;

  logic [ACCL_LATENCY-1:0] acc_v, acc_last;
  logic [AW-1:0]           acc_i [ACCL_LATENCY];
  logic [UPD_LATENCY-1:0]  upd_v;
  logic [AW-1:0]           upd_a [UPD_LATENCY];

  logic          start_edge, at_row_end, at_last_pair, final_write, more_steps, i_is_last;
  logic [AW:0]   n_clamped, last_idx, row_last_j;
  logic [AW-1:0] j_inc;

  always_comb begin
    start_edge   = start & ~start_q;
    n_clamped    = (num_bodies > BODIES_W) ? BODIES_W : num_bodies;
    last_idx     = n_lat - ONE_N;
    i_is_last    = ({1'b0, i_cnt} == last_idx);
    // With self pairs skipped, the last row ends one column early.
    row_last_j   = (SKIP_SELF && i_is_last) ? (n_lat - TWO_N) : last_idx;
    at_row_end   = ({1'b0, j_cnt} == row_last_j);
    at_last_pair = at_row_end && i_is_last;
    j_inc        = j_cnt + ONE_A;
    final_write  = upd_v[UPD_LATENCY-1] && ({1'b0, upd_a[UPD_LATENCY-1]} == last_idx);
    more_steps   = ({1'b0, step_count} + 17'd1) < {1'b0, s_lat};
  end

  assign issue_valid = (state == S_ISSUE);
  assign busy        = (state != S_IDLE) && (state != S_DONE);
  assign done        = (state == S_DONE);
  assign rd_i        = i_cnt;
  assign rd_j        = j_cnt;
  assign pos_rd_addr = u_cnt;
  assign res_valid   = acc_v[ACCL_LATENCY-1];
  assign res_last    = acc_last[ACCL_LATENCY-1];
  assign res_i       = acc_i[ACCL_LATENCY-1];
  assign pos_wren    = upd_v[UPD_LATENCY-1];
  assign pos_wr_addr = upd_a[UPD_LATENCY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst || abort) begin
      acc_v    <= '0;
      acc_last <= '0;
      upd_v    <= '0;
      for (int unsigned k = 0; k < ACCL_LATENCY; k++) acc_i[k] <= '0;
      for (int unsigned k = 0; k < UPD_LATENCY; k++) upd_a[k] <= '0;
    end else begin
      acc_v[0]    <= issue_valid;
      acc_i[0]    <= i_cnt;
      acc_last[0] <= issue_valid && at_row_end;
      for (int unsigned k = 1; k < ACCL_LATENCY; k++) begin
        acc_v[k]    <= acc_v[k-1];
        acc_i[k]    <= acc_i[k-1];
        acc_last[k] <= acc_last[k-1];
      end
      upd_v[0] <= (state == S_UPDATE) && !rd_done;
      upd_a[0] <= u_cnt;
      for (int unsigned k = 1; k < UPD_LATENCY; k++) begin
        upd_v[k] <= upd_v[k-1];
        upd_a[k] <= upd_a[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      start_q    <= 1'b1;  // a start level held through reset is not an edge
      n_lat      <= '0;
      s_lat      <= '0;
      i_cnt      <= '0;
      j_cnt      <= '0;
      u_cnt      <= '0;
      rd_done    <= 1'b0;
      step_count <= '0;
    end else begin
      start_q <= start;
      if (abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: if (start_edge) begin
            n_lat      <= n_clamped;
            s_lat      <= (num_steps == 16'd0) ? 16'd1 : num_steps;
            step_count <= '0;
            i_cnt      <= '0;
            j_cnt      <= FIRST_J;
            if (n_clamped == '0)             state <= S_DONE;
            else if (n_clamped < MIN_PAIR_N) state <= S_DRAIN;
            else                             state <= S_ISSUE;
          end
          S_ISSUE: begin
            if (at_last_pair) begin
              state <= S_DRAIN;
            end else if (at_row_end) begin
              i_cnt <= i_cnt + ONE_A;
              j_cnt <= '0;
            end else if (SKIP_SELF && (j_inc == i_cnt)) begin
              j_cnt <= j_inc + ONE_A;
            end else begin
              j_cnt <= j_inc;
            end
          end
          S_DRAIN: if (acc_v == '0) begin
            state   <= S_UPDATE;
            u_cnt   <= '0;
            rd_done <= 1'b0;
          end
          S_UPDATE: begin
            if (!rd_done) begin
              if ({1'b0, u_cnt} == last_idx) rd_done <= 1'b1;
              else                           u_cnt   <= u_cnt + ONE_A;
            end
            if (final_write) begin
              step_count <= step_count + 16'd1;
              if (more_steps) begin
                i_cnt <= '0;
                j_cnt <= FIRST_J;
                state <= (n_lat < MIN_PAIR_N) ? S_DRAIN : S_ISSUE;
              end else begin
                state <= S_DONE;
              end
            end
          end
          S_DONE: if (ack) state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_nbody_pair_sched.sv
// Randomized self-checking bench for nbody_pair_sched against a pair-list reference model.
module tb_nbody_pair_sched;
  localparam int BOD = 8;
  localparam int AW  = 3;
  localparam int AL  = 4;
  localparam int UL  = 2;

`ifdef NBODY_SKIP_SELF_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, ack, abort;
  logic [AW:0]   num_bodies;
  logic [15:0]   num_steps;
  logic [AW-1:0] rd_i, rd_j, res_i, pos_rd_addr, pos_wr_addr;
  logic          issue_valid, res_valid, res_last, pos_wren, busy, done;
  logic [15:0]   step_count;

  nbody_pair_sched #(.BODIES(BOD), .ACCL_LATENCY(AL), .UPD_LATENCY(UL)) dut (
    .clk(clk), .rst(rst), .start(start), .ack(ack), .abort(abort),
    .num_bodies(num_bodies), .num_steps(num_steps),
    .rd_i(rd_i), .rd_j(rd_j), .issue_valid(issue_valid),
    .res_valid(res_valid), .res_i(res_i), .res_last(res_last),
    .pos_rd_addr(pos_rd_addr), .pos_wr_addr(pos_wr_addr), .pos_wren(pos_wren),
    .busy(busy), .done(done), .step_count(step_count)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; int a; int b; } ev_t;
  ev_t iss_q[$], res_q[$], wr_q[$];
  int  rd_hist[int];
  int  cyc = 0;
  int  n_chk = 0, n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (!rst) begin
    if (issue_valid) iss_q.push_back('{cyc, int'(rd_i), int'(rd_j)});
    if (res_valid)   res_q.push_back('{cyc, int'(res_i), int'(res_last)});
    if (pos_wren)    wr_q.push_back('{cyc, int'(pos_wr_addr), 0});
    rd_hist[cyc] = int'(pos_rd_addr);
  end

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    iss_q.delete(); res_q.delete(); wr_q.delete();
  endtask

  // One full run: reference pair list from nested loops, then event-by-event comparison.
  task automatic do_run(input int n_in, input int s_in);
    int n_eff, s_eff, t0, w, done_cyc, npair, tot, m;
    int ei[$], ej[$], el[$];
    n_eff = (n_in > BOD) ? BOD : n_in;
    s_eff = (s_in == 0) ? 1 : s_in;
    for (int i = 0; i < n_eff; i++)
      for (int j = 0; j < n_eff; j++) begin
        if (SKIP && i == j) continue;
        ei.push_back(i); ej.push_back(j);
      end
    npair = ei.size();
    for (int k = 0; k < npair; k++)
      el.push_back((k == npair - 1 || ei[k+1] != ei[k]) ? 1 : 0);

    clear_logs();
    @(posedge clk); #1;
    num_bodies = (AW+1)'(n_in);
    num_steps  = 16'(s_in);
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    num_bodies = (AW+1)'($urandom_range(0, 15));
    num_steps  = 16'($urandom_range(0, 7));
    w = 0;
    while (done !== 1'b1 && w < 5000) begin @(negedge clk); w++; end
    done_cyc = cyc;
    chk_eq("done_seen", int'(done), 1);
    chk_eq("busy_at_done", int'(busy), 0);
    chk_eq("step_count", int'(step_count), (n_eff == 0) ? 0 : s_eff);
    if (n_eff == 0) chk_eq("n0_done_lat", done_cyc, t0 + 1);

    tot = (n_eff == 0) ? 0 : s_eff * npair;
    chk_eq("iss_cnt", iss_q.size(), tot);
    m = (iss_q.size() < tot) ? iss_q.size() : tot;
    for (int k = 0; k < m; k++) begin
      chk_eq("iss_i", iss_q[k].a, ei[k % npair]);
      chk_eq("iss_j", iss_q[k].b, ej[k % npair]);
      if (k == 0) chk_eq("first_iss_lat", iss_q[k].cyc, t0 + 1);
      else if (k % npair != 0) chk_eq("iss_consec", iss_q[k].cyc, iss_q[k-1].cyc + 1);
    end
    chk_eq("res_cnt", res_q.size(), tot);
    m = (res_q.size() < m) ? res_q.size() : m;
    for (int k = 0; k < m; k++) begin
      chk_eq("res_lat", res_q[k].cyc, iss_q[k].cyc + AL);
      chk_eq("res_i", res_q[k].a, ei[k % npair]);
      chk_eq("res_last", res_q[k].b, el[k % npair]);
    end

    tot = (n_eff == 0) ? 0 : s_eff * n_eff;
    chk_eq("wr_cnt", wr_q.size(), tot);
    m = (wr_q.size() < tot) ? wr_q.size() : tot;
    for (int k = 0; k < m; k++) begin
      chk_eq("wr_addr", wr_q[k].a, k % n_eff);
      chk_eq("wr_lat", rd_hist.exists(wr_q[k].cyc - UL) ? rd_hist[wr_q[k].cyc - UL] : -1, wr_q[k].a);
    end
    if (m > 0) chk_eq("done_after_wr", int'(done_cyc > wr_q[m-1].cyc), 1);

    repeat (3) @(negedge clk);
    chk_eq("done_hold", int'(done), 1);
    @(posedge clk); #1; ack = 1'b1;
    @(posedge clk); #1; ack = 1'b0;
    @(negedge clk);
    chk_eq("ack_done_clr", int'(done), 0);
    chk_eq("ack_idle", int'(busy), 0);
  endtask

  task automatic do_abort();
    int t0, late;
    clear_logs();
    @(posedge clk); #1;
    num_bodies = 4'd4; num_steps = 16'd1; start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    chk_eq("abort_iv", int'(issue_valid), 0);
    chk_eq("abort_busy", int'(busy), 0);
    chk_eq("abort_rv", int'(res_valid), 0);
    repeat (12) @(negedge clk);
    late = 0;
    foreach (res_q[k]) if (res_q[k].cyc >= t0 + 6) late++;
    chk_eq("abort_no_res", late, 0);
    chk_eq("abort_iss_cnt", iss_q.size(), 5);
    chk_eq("abort_wr_cnt", wr_q.size(), 0);
    chk_eq("abort_steps_hold", int'(step_count), 0);
  endtask

  task automatic do_reset_in_update();
    int w;
    clear_logs();
    @(posedge clk); #1;
    num_bodies = 4'd3; num_steps = 16'd2; start = 1'b1;
    w = 0;
    while (wr_q.size() == 0 && w < 2000) begin @(negedge clk); w++; end
    chk_eq("rst_reached_update", int'(wr_q.size() > 0), 1);
    @(posedge clk); #1; rst = 1'b1; #1;
    chk_eq("rst_iv", int'(issue_valid), 0);
    chk_eq("rst_rv", int'(res_valid), 0);
    chk_eq("rst_rl", int'(res_last), 0);
    chk_eq("rst_wren", int'(pos_wren), 0);
    chk_eq("rst_busy", int'(busy), 0);
    chk_eq("rst_done", int'(done), 0);
    chk_eq("rst_addrs", int'({rd_i, rd_j, pos_rd_addr, pos_wr_addr, res_i}), 0);
    chk_eq("rst_steps", int'(step_count), 0);
    @(posedge clk); #1; rst = 1'b0;
    clear_logs();
    repeat (20) @(negedge clk);
    chk_eq("held_start_idle", int'(busy), 0);
    chk_eq("held_start_no_iss", iss_q.size(), 0);
    chk_eq("held_start_no_wr", wr_q.size(), 0);
    chk_eq("held_start_no_done", int'(done), 0);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ack = 1'b0; abort = 1'b0;
    num_bodies = '0; num_steps = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("reset_busy", int'(busy), 0);
    chk_eq("reset_done", int'(done), 0);
    chk_eq("reset_iv", int'(issue_valid), 0);
    chk_eq("reset_steps", int'(step_count), 0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk);

    do_run(3, 1);
    do_run(2, 3);
    do_run(0, 1);
    do_run(12, 1);
    do_run(1, 2);
    do_abort();
    for (int r = 0; r < 10; r++)
      do_run(int'($urandom_range(0, 10)), int'($urandom_range(0, 3)));
    do_reset_in_update();
    do_run(4, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
